ritc_capture_buffer: RTL and testbench
======================================

// Module: ritc_capture_buffer
// PURPOSE
//  Parametrised multi-channel pre/post-trigger capture buffer for RITC sample data.
//  Free-runs a circular write while armed, then freezes DEPTH samples around the trigger:
//  PRE samples before it, the rest at and after it. Readout is in the same clock domain,
//  per channel, with addresses relative to the oldest stored sample.
//  Sits between the RITC deserializer outputs and the register-bus readout logic.
// PARAMETERS
//  NCH  6   number of channels
//  SW   48  bits per channel per sysclk (one deserialized sample group)
//  AW   9   address width; DEPTH = 2**AW entries per channel
//  CW   3   channel-select width; must satisfy 2**CW >= NCH
// PORTS
//  sysclk_i      in   1       sole clock; all logic on rising edge
//  rst_n_i       in   1       asynchronous, active-low reset
//  dat_i         in   NCH*SW  channel c occupies bits [c*SW +: SW]
//  sync_i        in   1       RITC sync phase; latched on the trigger cycle
//  arm_i         in   1       pulse: start circular capture
//  trig_i        in   1       pulse: trigger
//  clear_i       in   1       pulse: abort or discard capture, return to IDLE
//  pretrig_i     in   AW      pre-trigger sample count; sampled when arm is accepted
//  rd_ch_i       in   CW      channel to read
//  rd_addr_i     in   AW      logical read address (0 = oldest sample)
//  rd_load_i     in   1       load rd_addr_i into the read pointer
//  rd_en_i       in   1       read at the pointer, then post-increment the pointer
//  rd_dat_o      out  SW      read data
//  rd_valid_o    out  1       rd_dat_o valid strobe
//  busy_o        out  1       high in ARMED or POST
//  done_o        out  1       high in DONE
//  trig_addr_o   out  AW      physical address of the trigger sample
//  sync_latch_o  out  1       sync_i value on the accepted trigger cycle
// BEHAVIOUR
//  Reset: state = IDLE. All pointers and counters = 0. All outputs = 0.
//  Storage: one inferred simple-dual-port RAM, DEPTH x (NCH*SW). No output register.
//  States:
//  - IDLE: no writes. arm_i -> ARMED; wptr <= 0, fill <= 0, pre <= pretrig_i.
//  - ARMED: write dat_i at wptr every cycle; wptr wraps modulo DEPTH;
//    fill saturates at DEPTH-1.
//    trig_i is accepted only when fill >= pre; otherwise it is ignored and state stays ARMED.
//    On acceptance:
//      the sample written that cycle is the trigger sample;
//      trig_addr_o <= wptr, sync_latch_o <= sync_i, post <= DEPTH-pre-1;
//      -> POST, or -> DONE directly when post == 0.
//  - POST: write every cycle and decrement post; the write made at post == 1 is the last -> DONE.
//  - DONE: writes stop. base = (trig_addr - pre) mod DEPTH = oldest sample.
//    arm_i starts a new capture, with done_o falling the next cycle.
//  Frozen buffer layout: logical L holds trigger sample offset (L - pre);
//    L = pre is the trigger sample.
//  pretrig_i = 0 means the trigger sample is logical 0.
//    pretrig_i >= DEPTH is clamped to DEPTH-1.
//  clear_i: any state -> IDLE next cycle.
//    done_o/busy_o drop; trig_addr_o and sync_latch_o are held.
//  Priority: clear_i > arm_i > trig_i on the same cycle. arm_i in ARMED or POST restarts the capture.
//  Readout:
//  - rd_load_i sets rptr <= rd_addr_i. If rd_en_i is also high,
//    the read uses the new address and rptr <= rd_addr_i + 1.
//  - rd_en_i in DONE: RAM address = (base + rptr) mod DEPTH; rptr increments, wrapping at DEPTH.
//  - Latency is 2 cycles (address register + RAM read).
//    rd_ch_i is pipelined alongside to pick the output slice.
//  - rd_valid_o pulses 2 cycles after each accepted rd_en_i.
//  - rd_en_i outside DONE is ignored: no valid, no increment.
//    rd_load_i is always accepted.
//  - rd_ch_i >= NCH returns 0 with valid.
//  - Reads already in flight when DONE is left still complete.
//  rd_dat_o holds its last value between strobes.
//  Mid-operation reset returns to IDLE asynchronously. RAM contents are undefined afterwards.
// TESTING
//  NCH=6, SW=48, AW=4 (DEPTH 16).
//  dat_i: channel c carries {c[7:0], k[39:0]} at cycle k after reset release.
//  1 Basic capture: arm at k=10, pretrig 4, trig at k=40.
//    -> trigger accepted; done_o rises after the write of k=51.
//    Read ch2 at L=0..15 -> k=36..51. rd_valid_o 2 cycles after each rd_en_i.
//    sync_latch_o = sync_i at k=40.
//  2 Early trigger: arm at k=10, pretrig 8, trig at k=13.
//    -> trigger ignored, busy_o stays high.
//    Second trig at k=30 -> logical 8 reads k=30.
//  3 Edge pretrig values:
//    pretrig 0 -> logical 0 = trigger sample; done_o after 15 more writes.
//    pretrig 15 -> done_o the cycle after the trigger; logical 15 = trigger.
//    pretrig 20 -> behaves as 15.
//  4 Wrap and readout: trigger with wptr at 14.
//    -> trig_addr_o=14; logical reads cross the physical wrap seamlessly.
//    rd_load 15 then 3 rd_en -> logical 15, 0, 1.
//  5 Simultaneous events:
//    clear+trig -> IDLE, no capture. arm+clear -> IDLE.
//    arm in POST -> restart with fill=0.
//    rd_en in IDLE -> no rd_valid_o.
//  6 Reset mid-POST: rst_n_i low -> all outputs 0 immediately; a new arm after release captures normally.

Source files
------------

// File: rtl/ritc_capture_buffer.sv
// Multi-channel pre/post-trigger capture buffer: circular write while armed, freezes DEPTH samples around the trigger.
// Latency: read data 2 cycles after an accepted rd_en_i (address register + RAM read).
// Backpressure: none; writes follow sysclk_i every cycle in ARMED/POST, reads are accepted only in DONE.
module ritc_capture_buffer #(
    parameter int NCH = 6,
    parameter int SW  = 48,
    parameter int AW  = 9,
    parameter int CW  = 3
) (
    input  logic               sysclk_i,
    input  logic               rst_n_i,
    input  logic [NCH*SW-1:0]  dat_i,
    input  logic               sync_i,
    input  logic               arm_i,
    input  logic               trig_i,
    input  logic               clear_i,
    input  logic [AW-1:0]      pretrig_i,
    input  logic [CW-1:0]      rd_ch_i,
    input  logic [AW-1:0]      rd_addr_i,
    input  logic               rd_load_i,
    input  logic               rd_en_i,
    output logic [SW-1:0]      rd_dat_o,
    output logic               rd_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [AW-1:0]      trig_addr_o,
    output logic               sync_latch_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, fill_q, pre_q, post_q, trig_addr_q;
    logic              sync_q;
    logic              arm_acc, trig_acc, wr_en, rd_acc;

    logic [NCH*SW-1:0] mem [DEPTH];
    logic [NCH*SW-1:0] ram_q;
    logic [AW-1:0]     rptr_q, raddr_q, base, rd_ptr_eff;
    logic [CW-1:0]     ch1_q, ch2_q;
    logic              vld1_q, vld2_q, seen_q;

    assign arm_acc  = arm_i & ~clear_i;
    // A trigger only counts once PRE samples precede it in the ring.
    assign trig_acc = (state_q == S_ARMED) & trig_i & ~arm_i & ~clear_i & (fill_q >= pre_q);
    assign wr_en    = (state_q == S_ARMED) | (state_q == S_POST);

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else if (arm_i) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: if (trig_acc) state_d = (pre_q == LAST) ? S_DONE : S_POST;
                S_POST:  if (post_q == AW'(1)) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_ARMED, S_POST: busy_o = 1'b1;
            S_DONE:          done_o = 1'b1;
            default:         busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q      <= '0;
            fill_q      <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            trig_addr_q <= '0;
            sync_q      <= 1'b0;
        end else begin
            if (arm_acc) begin
                wptr_q <= '0;
                fill_q <= '0;
                pre_q  <= pretrig_i;
            end else if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
                if ((state_q == S_ARMED) && (fill_q != LAST)) fill_q <= fill_q + AW'(1);
            end
            if (trig_acc) begin
                trig_addr_q <= wptr_q;
                sync_q      <= sync_i;
                post_q      <= LAST - pre_q;
            end else if ((state_q == S_POST) && (post_q != '0)) begin
                post_q <= post_q - AW'(1);
            end
        end
    end

    assign trig_addr_o  = trig_addr_q;
    assign sync_latch_o = sync_q;

    always_ff @(posedge sysclk_i) begin
        if (wr_en) mem[wptr_q] <= dat_i;
    end

    // Logical addresses are relative to the oldest frozen sample.
    assign base       = trig_addr_q - pre_q;
    assign rd_ptr_eff = rd_load_i ? rd_addr_i : rptr_q;
    assign rd_acc     = rd_en_i & (state_q == S_DONE);

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rptr_q  <= '0;
            raddr_q <= '0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            if (rd_acc) begin
                rptr_q  <= rd_ptr_eff + AW'(1);
                raddr_q <= base + rd_ptr_eff;
                ch1_q   <= rd_ch_i;
            end else if (rd_load_i) begin
                rptr_q <= rd_addr_i;
            end
            vld1_q <= rd_acc;
            vld2_q <= vld1_q;
            if (vld1_q) begin
                ch2_q  <= ch1_q;
                seen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (vld1_q) ram_q <= mem[raddr_q];
    end

    // Slice select after the RAM; out-of-range channels read as zero.
    always_comb begin
        rd_dat_o = '0;
        if (seen_q) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch2_q == CW'(c)) rd_dat_o = ram_q[c*SW +: SW];
            end
        end
    end

    assign rd_valid_o = vld2_q;

endmodule

// File: tb/tb_ritc_capture_buffer.sv
// Bench for ritc_capture_buffer: table-driven captures, corner sequences and randomized captures/reads.
module tb_ritc_capture_buffer;

    localparam int NCH = 6, SW = 48, AW = 4, CW = 3, DEPTH = 16;

    logic               sysclk_i = 1'b0;
    logic               rst_n_i;
    logic [NCH*SW-1:0]  dat_i;
    logic               sync_i, arm_i, trig_i, clear_i, rd_load_i, rd_en_i;
    logic [AW-1:0]      pretrig_i, rd_addr_i;
    logic [CW-1:0]      rd_ch_i;
    logic [SW-1:0]      rd_dat_o;
    logic               rd_valid_o, busy_o, done_o, sync_latch_o;
    logic [AW-1:0]      trig_addr_o;

    ritc_capture_buffer #(.NCH(NCH), .SW(SW), .AW(AW), .CW(CW)) dut (
        .sysclk_i(sysclk_i), .rst_n_i(rst_n_i), .dat_i(dat_i), .sync_i(sync_i),
        .arm_i(arm_i), .trig_i(trig_i), .clear_i(clear_i), .pretrig_i(pretrig_i),
        .rd_ch_i(rd_ch_i), .rd_addr_i(rd_addr_i), .rd_load_i(rd_load_i), .rd_en_i(rd_en_i),
        .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o), .done_o(done_o),
        .trig_addr_o(trig_addr_o), .sync_latch_o(sync_latch_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    typedef struct {
        int pre; int ge; int g; int lat; int taddr; int ch;
    } vec_t;
    typedef struct {
        int due; logic [SW-1:0] dat;
    } rd_exp_t;

    int          checks = 0, errors = 0;
    int          k = 0;
    int          m_pre, m_arm_k, cap_t, cap_pre, rptr_m;
    logic        exp_sync;
    logic [SW-1:0] last_dat;
    rd_exp_t     rq[$];
    vec_t        tbl[7];

    function automatic logic [NCH*SW-1:0] mk(input int kk);
        logic [NCH*SW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*SW +: SW] = {8'(c), 40'(kk)};
        return v;
    endfunction

    // Logical L of the frozen capture holds the sample taken (L - pre) cycles from the trigger.
    function automatic logic [SW-1:0] exp_word(input int ch, input int L);
        if (ch >= NCH) return '0;
        return {8'(ch), 40'(cap_t - cap_pre + L)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (k=%0d)", nm, act, exp, k);
        end
    endtask

    task automatic tick;
        bit exp_v;
        @(posedge sysclk_i);
        #1;
        k++;
        dat_i = mk(k);
        sync_i = 1'($urandom);
        pretrig_i = 4'($urandom);
        arm_i = 0; trig_i = 0; clear_i = 0; rd_en_i = 0; rd_load_i = 0;
        exp_v = 0;
        if (rq.size() > 0) exp_v = (rq[0].due == k);
        chk("rd_valid", 64'(rd_valid_o), 64'(exp_v));
        if (exp_v) begin
            chk("rd_dat", 64'(rd_dat_o), 64'(rq[0].dat));
            last_dat = rq[0].dat;
            void'(rq.pop_front());
        end else begin
            chk("rd_dat_hold", 64'(rd_dat_o), 64'(last_dat));
        end
    endtask

    task automatic do_arm(input int pre);
        arm_i = 1; pretrig_i = 4'(pre);
        m_pre = pre; m_arm_k = k;
        tick;
    endtask

    task automatic do_trig(input bit acc);
        trig_i = 1;
        if (acc) begin
            cap_t = k; cap_pre = m_pre; exp_sync = sync_i;
        end
        tick;
    endtask

    task automatic issue_read(input int ch, input bit load, input int addr, input bit acc);
        int L;
        rd_ch_i = 3'(ch); rd_addr_i = 4'(addr); rd_load_i = load; rd_en_i = 1;
        L = load ? addr : rptr_m;
        if (acc) begin
            rq.push_back('{due: k + 2, dat: exp_word(ch, L)});
            rptr_m = (L + 1) % DEPTH;
        end else if (load) begin
            rptr_m = addr;
        end
        tick;
    endtask

    task automatic wait_done(input int lat);
        for (int i = 0; i <= lat; i++) begin
            chk("done_timing", 64'(done_o), 64'(i == lat));
            chk("busy_timing", 64'(busy_o), 64'(i != lat));
            if (i < lat) tick;
        end
    endtask

    task automatic read_all(input int ch);
        issue_read(ch, 1, 0, 1);
        for (int L = 1; L < DEPTH; L++) issue_read(ch, 0, 0, 1);
        issue_read(ch, 1, 15, 1);
        issue_read(ch, 0, 0, 1);
        issue_read(ch, 0, 0, 1);
        repeat (3) tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, pre, gap, g2, prev_taddr;
        bit acc;

        tbl[0] = '{4, 0, 30, 11, 13, 2};
        tbl[1] = '{0, 0, 1, 15, 0, 0};
        tbl[2] = '{15, 0, 16, 0, 15, 5};
        tbl[3] = '{15, 15, 20, 0, 3, 1};
        tbl[4] = '{8, 3, 20, 7, 3, 3};
        tbl[5] = '{7, 0, 8, 8, 7, 6};
        tbl[6] = '{3, 0, 15, 12, 14, 4};

        rst_n_i = 0; sync_i = 0; arm_i = 0; trig_i = 0; clear_i = 0;
        rd_load_i = 0; rd_en_i = 0; pretrig_i = '0; rd_addr_i = '0; rd_ch_i = '0;
        dat_i = mk(0); last_dat = '0; rptr_m = 0; exp_sync = 0;
        #12;
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_done", 64'(done_o), 0);
        chk("rst_trig_addr", 64'(trig_addr_o), 0);
        chk("rst_sync", 64'(sync_latch_o), 0);
        chk("rst_valid", 64'(rd_valid_o), 0);
        chk("rst_dat", 64'(rd_dat_o), 0);
        @(posedge sysclk_i); #1;
        rst_n_i = 1; k = 0; dat_i = mk(0);

        while (k < 10) tick;
        for (int r = 0; r < 7; r++) begin
            do_arm(tbl[r].pre);
            a = m_arm_k;
            if (tbl[r].ge != 0) begin
                while (k < a + tbl[r].ge) tick;
                do_trig(0);
                chk("early_trig_busy", 64'(busy_o), 1);
                chk("early_trig_done", 64'(done_o), 0);
            end
            while (k < a + tbl[r].g) tick;
            do_trig(1);
            wait_done(tbl[r].lat);
            chk("tbl_trig_addr", 64'(trig_addr_o), 64'(tbl[r].taddr));
            chk("tbl_sync", 64'(sync_latch_o), 64'(exp_sync));
            read_all(tbl[r].ch);
            clear_i = 1; tick;
            chk("clear_done", 64'(done_o), 0);
        end

        // clear together with an acceptable trigger: no capture, frozen outputs kept
        prev_taddr = 14;
        do_arm(2); a = m_arm_k;
        while (k < a + 6) tick;
        trig_i = 1; clear_i = 1; tick;
        chk("clrtrig_busy", 64'(busy_o), 0);
        chk("clrtrig_taddr", 64'(trig_addr_o), 64'(prev_taddr));
        chk("clrtrig_sync", 64'(sync_latch_o), 64'(exp_sync));
        repeat (20) tick;
        chk("clrtrig_no_done", 64'(done_o), 0);

        arm_i = 1; clear_i = 1; tick;
        chk("armclr_busy", 64'(busy_o), 0);

        // reads outside DONE: no strobe, but the load still sets the pointer
        issue_read(1, 1, 5, 0);
        issue_read(1, 0, 0, 0);
        repeat (3) tick;

        // re-arm during POST restarts with an empty ring
        do_arm(2); a = m_arm_k;
        while (k < a + 5) tick;
        do_trig(1);
        repeat (3) tick;
        chk("post_busy", 64'(busy_o), 1);
        do_arm(3); a = m_arm_k;
        do_trig(0);
        chk("restart_busy", 64'(busy_o), 1);
        chk("restart_done", 64'(done_o), 0);
        while (k < a + 10) tick;
        do_trig(1);
        wait_done(12);
        chk("restart_taddr", 64'(trig_addr_o), 9);
        issue_read(3, 0, 0, 1);
        issue_read(3, 0, 0, 1);
        repeat (3) tick;
        read_all(2);

        // asynchronous reset in the middle of POST
        clear_i = 1; tick;
        do_arm(5); a = m_arm_k;
        while (k < a + 8) tick;
        do_trig(1);
        repeat (3) tick;
        #2 rst_n_i = 0;
        #1;
        chk("mrst_busy", 64'(busy_o), 0);
        chk("mrst_done", 64'(done_o), 0);
        chk("mrst_taddr", 64'(trig_addr_o), 0);
        chk("mrst_sync", 64'(sync_latch_o), 0);
        chk("mrst_valid", 64'(rd_valid_o), 0);
        chk("mrst_dat", 64'(rd_dat_o), 0);
        last_dat = '0; rptr_m = 0; rq.delete(); exp_sync = 0;
        repeat (2) tick;
        rst_n_i = 1;
        tick;
        do_arm(6); a = m_arm_k;
        while (k < a + 10) tick;
        do_trig(1);
        wait_done(9);
        chk("mrst_new_taddr", 64'(trig_addr_o), 9);
        chk("mrst_new_sync", 64'(sync_latch_o), 64'(exp_sync));
        read_all(4);

        // randomized captures against the reference model
        for (int it = 0; it < 30; it++) begin
            pre = $urandom_range(0, 15);
            gap = $urandom_range(1, 24);
            prev_taddr = int'(trig_addr_o);
            if ($urandom_range(0, 1) == 1) begin
                arm_i = 1; pretrig_i = 4'(pre); m_pre = pre; m_arm_k = k;
                issue_read($urandom_range(0, 7), 0, 0, 1);
                chk("rnd_done_fall", 64'(done_o), 0);
            end else begin
                clear_i = 1; tick;
                chk("rnd_clear_done", 64'(done_o), 0);
                chk("rnd_clear_taddr", 64'(trig_addr_o), 64'(prev_taddr));
                do_arm(pre);
            end
            a = m_arm_k;
            acc = (gap - 1 >= pre);
            while (k < a + gap) tick;
            do_trig(acc);
            if (!acc) begin
                chk("rnd_ignored_busy", 64'(busy_o), 1);
                g2 = pre + 1 + $urandom_range(0, 5);
                while (k < a + g2) tick;
                do_trig(1);
            end
            wait_done(15 - pre);
            chk("rnd_taddr", 64'(trig_addr_o), 64'((cap_t - a - 1) % DEPTH));
            chk("rnd_sync", 64'(sync_latch_o), 64'(exp_sync));
            for (int j = 0; j < 6; j++)
                issue_read($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1);
        end
        repeat (4) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
